pll_reconf_sequencer: RTL

Drives the Altera altpll_reconfig megafunction and its scan-chain ROM through a full PLL reconfiguration whenever the requested video-mode index changes, and runs one sequence after reset.

---
 rtl/pll_reconf_pkg.sv | 38 +++
 rtl/pll_reconf_timer.sv | 35 +++
 rtl/pll_reconf_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_reconf_pkg.sv
// Shared types and defaults for the PLL reconfiguration sequencer.
// Contents:
//   state_e      - sequencer states
//   DEF_*        - default parameter values
//   timer_width  - bits needed by the shared wait timer to reach its largest limit
package pll_reconf_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    WAIT_LOAD,
    RECONF,
    WAIT_RECONF,
    WAIT_LOCK,
    ARESET,
    SETTLE,
    DONE
  } state_e;

  localparam int unsigned DEF_CFG_W         = 8;
  localparam int unsigned DEF_BUSY_TIMEOUT  = 4096;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 65535;
  localparam int unsigned DEF_SETTLE_CYCLES = 256;
  localparam int unsigned DEF_ARESET_CYCLES = 16;
  localparam int unsigned DEF_MAX_RETRIES   = 3;

  // The timer must be able to hold the limit value itself, hence m + 1.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_reconf_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset
//   clr_i         - count is treated as zero this cycle (first cycle of a state)
//   en_i          - advance the count
//   limit_i       - terminal count
//   tc_o          - count equals limit_i
module pll_reconf_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d, count_eff;

  // Clear acts combinationally so the first cycle of a state already reads 0.
  assign count_eff = clr_i ? '0 : count_q;
  assign tc_o      = (count_eff == limit_i);

  always_comb begin
    count_d = count_eff;
    if (en_i && (count_eff != '1)) count_d = count_eff + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/pll_reconf_sequencer.sv
// Sequences altpll_reconfig and its scan-chain ROM through a full PLL
// reconfiguration on every change of the requested mode index (and once after
// reset), holding downstream logic in reset until the new clock has settled.
// Ports:
//   clock_i, reset_i      - clock, synchronous active-high reset
//   cfg_sel_i             - requested config index
//   reconf_busy_i         - altpll_reconfig busy
//   pll_locked_i          - PLL lock (already synchronised)
//   rom_sel_o             - index presented to the ROM, frozen during a sequence
//   write_from_rom_o      - one-cycle ROM load strobe
//   reconfig_o            - one-cycle reconfig strobe
//   pll_areset_o          - PLL reset during lock retries
//   out_reset_o           - downstream reset
//   cfg_applied_o         - last successfully applied index
//   ready_o               - locked and settled on cfg_applied_o
//   busy_timeout_o        - sticky busy-wait timeout
//   lock_error_o          - sticky lock failure after all retries
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | waiting for a new index, or watching lock while ready
// LOAD        | write_from_rom strobe
// WAIT_LOAD   | waiting for the ROM load busy pulse to complete
// RECONF      | reconfig strobe
// WAIT_RECONF | waiting for the reconfig busy pulse to complete
// WAIT_LOCK   | waiting for pll_locked, retries on timeout
// ARESET      | pll_areset held for a fixed time
// SETTLE      | counting consecutive locked cycles
// DONE        | commit cfg_applied, release downstream
module pll_reconf_sequencer
  import pll_reconf_pkg::*;
#(
  parameter int unsigned CFG_W         = DEF_CFG_W,
  parameter int unsigned BUSY_TIMEOUT  = DEF_BUSY_TIMEOUT,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned ARESET_CYCLES = DEF_ARESET_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [CFG_W-1:0] cfg_sel_i,
  input  logic             reconf_busy_i,
  input  logic             pll_locked_i,
  output logic [CFG_W-1:0] rom_sel_o,
  output logic             write_from_rom_o,
  output logic             reconfig_o,
  output logic             pll_areset_o,
  output logic             out_reset_o,
  output logic [CFG_W-1:0] cfg_applied_o,
  output logic             ready_o,
  output logic             busy_timeout_o,
  output logic             lock_error_o
);

  localparam int unsigned TMR_W  = timer_width(BUSY_TIMEOUT, LOCK_TIMEOUT, SETTLE_CYCLES, ARESET_CYCLES);
  localparam int unsigned RTRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TMR_W-1:0]  BUSY_LIM   = TMR_W'(BUSY_TIMEOUT);
  localparam logic [TMR_W-1:0]  LOCK_LIM   = TMR_W'(LOCK_TIMEOUT);
  // SETTLE and ARESET limits are "cycles spent", the timer starts at 0.
  localparam logic [TMR_W-1:0]  SETTLE_LIM = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  ARESET_LIM = TMR_W'(ARESET_CYCLES - 1);
  localparam logic [RTRY_W-1:0] MAX_RTRY   = RTRY_W'(MAX_RETRIES);

  state_e              state_q, state_prev_q;
  logic                pending_q, seen_busy_q;
  logic [CFG_W-1:0]    rom_sel_q, cfg_applied_q;
  logic                wfr_q, reconfig_q, areset_q, out_reset_q, ready_q;
  logic                busy_to_q, lock_err_q;
  logic [RTRY_W-1:0]   retries_q;

  logic                start;
  logic                tmr_clr, tmr_en, tmr_tc;
  logic [TMR_W-1:0]    tmr_limit;

  assign start = (pending_q || (cfg_sel_i != cfg_applied_q)) && !reconf_busy_i;

  // Every transition goes to a different state, so a state change marks entry.
  assign tmr_clr = (state_q != state_prev_q);
  assign tmr_en  = (state_q != IDLE);

  always_comb begin
    tmr_limit = BUSY_LIM;
    case (state_q)
      WAIT_LOCK: tmr_limit = LOCK_LIM;
      ARESET:    tmr_limit = ARESET_LIM;
      SETTLE:    tmr_limit = SETTLE_LIM;
      default:   tmr_limit = BUSY_LIM;
    endcase
  end

  pll_reconf_timer #(.W(TMR_W)) u_timer (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      state_prev_q  <= IDLE;
      pending_q     <= 1'b1;
      seen_busy_q   <= 1'b0;
      rom_sel_q     <= '0;
      cfg_applied_q <= '0;
      wfr_q         <= 1'b0;
      reconfig_q    <= 1'b0;
      areset_q      <= 1'b0;
      out_reset_q   <= 1'b1;
      ready_q       <= 1'b0;
      busy_to_q     <= 1'b0;
      lock_err_q    <= 1'b0;
      retries_q     <= '0;
    end else begin
      state_prev_q <= state_q;
      wfr_q        <= 1'b0;
      reconfig_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rom_sel_q   <= cfg_sel_i;
            pending_q   <= 1'b0;
            out_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            retries_q   <= '0;
            wfr_q       <= 1'b1;
            state_q     <= LOAD;
          end else if (ready_q && !pll_locked_i) begin
            ready_q     <= 1'b0;
            out_reset_q <= 1'b1;
            retries_q   <= '0;
            state_q     <= WAIT_LOCK;
          end
        end
        LOAD, RECONF: begin
          // busy may already be up in the strobe cycle
          seen_busy_q <= reconf_busy_i;
          state_q     <= (state_q == LOAD) ? WAIT_LOAD : WAIT_RECONF;
        end
        WAIT_LOAD, WAIT_RECONF: begin
          if (seen_busy_q && !reconf_busy_i) begin
            if (state_q == WAIT_LOAD) begin
              reconfig_q <= 1'b1;
              state_q    <= RECONF;
            end else begin
              retries_q  <= '0;
              state_q    <= WAIT_LOCK;
            end
          end else if (tmr_tc) begin
            busy_to_q <= 1'b1;
            state_q   <= IDLE;
          end else if (reconf_busy_i) begin
            seen_busy_q <= 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (pll_locked_i) begin
            state_q <= SETTLE;
          end else if (tmr_tc) begin
            if (retries_q < MAX_RTRY) begin
              retries_q <= retries_q + 1'b1;
              areset_q  <= 1'b1;
              state_q   <= ARESET;
            end else begin
              lock_err_q  <= 1'b1;
              out_reset_q <= 1'b1;
              ready_q     <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        ARESET: begin
          if (tmr_tc) begin
            areset_q <= 1'b0;
            state_q  <= WAIT_LOCK;
          end
        end
        SETTLE: begin
          if (!pll_locked_i)  state_q <= WAIT_LOCK;
          else if (tmr_tc)    state_q <= DONE;
        end
        DONE: begin
          cfg_applied_q <= rom_sel_q;
          ready_q       <= 1'b1;
          out_reset_q   <= 1'b0;
          retries_q     <= '0;
          busy_to_q     <= 1'b0;
          lock_err_q    <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_sel_o        = rom_sel_q;
  assign write_from_rom_o = wfr_q;
  assign reconfig_o       = reconfig_q;
  assign pll_areset_o     = areset_q;
  assign out_reset_o      = out_reset_q;
  assign cfg_applied_o    = cfg_applied_q;
  assign ready_o          = ready_q;
  assign busy_timeout_o   = busy_to_q;
  assign lock_error_o     = lock_err_q;

endmodule
